// File: rtl/alu_pkg.sv
// Shared ALU definitions: funct encodings, datapath widths, operand bundle type
// and the saturating counter helper used by the arbiter statistics.
package alu_pkg;
    localparam int ALU_W   = 32;
    localparam int SHAMT_W = 5;
    localparam int FUNCT_W = 6;
    localparam int CNT_W   = 16;

    localparam logic [FUNCT_W-1:0] ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] XOR = 6'b100110;
    localparam logic [FUNCT_W-1:0] NOR = 6'b100111;
    localparam logic [FUNCT_W-1:0] SLL = 6'b000000;
    localparam logic [FUNCT_W-1:0] SRL = 6'b000010;
    localparam logic [FUNCT_W-1:0] SRA = 6'b000011;

    typedef struct packed {
        logic [ALU_W-1:0]   rs;
        logic [ALU_W-1:0]   rt;
        logic [FUNCT_W-1:0] funct;
        logic [SHAMT_W-1:0] shamt;
    } alu_req_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/alu.sv
// Combinational ALU. Shifts act on rs by shamt; unknown funct yields rd=0, zflag=1.
module alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0]   rs,
    input  logic [ALU_W-1:0]   rt,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [ALU_W-1:0]   rd,
    output logic               zflag
);
    always_comb begin
        rd = '0;
        case (funct)
            ADD:     rd = rs + rt;
            SUB:     rd = rs - rt;
            AND:     rd = rs & rt;
            OR:      rd = rs | rt;
            XOR:     rd = rs ^ rt;
            NOR:     rd = ~(rs | rt);
            SLL:     rd = rs << shamt;
            SRL:     rd = rs >> shamt;
            SRA:     rd = $signed(rs) >>> shamt;
            default: rd = '0;
        endcase
    end

    assign zflag = (rd == '0);
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or above ptr, wrapping to 0.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_vld
);
    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (en && !gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt_idx  = IDW'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters with round-robin grant and a single registered
// response stage. Define ALU_ARB_STATS_EN to add per-requester grant_cnt counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*ALU_W-1:0]   req_rs,
    input  logic [NREQ*ALU_W-1:0]   req_rt,
    input  logic [NREQ*FUNCT_W-1:0] req_funct,
    input  logic [NREQ*SHAMT_W-1:0] req_shamt,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [ALU_W-1:0]        rsp_rd,
    output logic                    rsp_zflag
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NREQ*CNT_W-1:0]   grant_cnt
`endif
);
    localparam int NSLOT = 2 ** IDW;

    logic            slot_free;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_vld;
    alu_req_t        lane [NSLOT];
    alu_req_t        sel;
    logic [ALU_W-1:0] alu_rd;
    logic            alu_z;

    // Gating with rstn keeps req_ready low while reset is held.
    assign slot_free = rstn && (!rsp_valid || rsp_ready);

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (slot_free),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Pad the lane table to a power of two so any gnt_idx value indexes in range.
    for (genvar i = 0; i < NSLOT; i++) begin : g_lane
        if (i < NREQ) begin : g_real
            assign lane[i] = '{rs:    req_rs[ALU_W*i +: ALU_W],
                               rt:    req_rt[ALU_W*i +: ALU_W],
                               funct: req_funct[FUNCT_W*i +: FUNCT_W],
                               shamt: req_shamt[SHAMT_W*i +: SHAMT_W]};
        end else begin : g_pad
            assign lane[i] = '0;
        end
    end

    assign sel = lane[gnt_idx];

    alu u_alu (
        .rs    (sel.rs),
        .rt    (sel.rt),
        .funct (sel.funct),
        .shamt (sel.shamt),
        .rd    (alu_rd),
        .zflag (alu_z)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rd    <= '0;
            rsp_zflag <= 1'b0;
            ptr       <= '0;
        end else if (gnt_vld) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_idx;
            rsp_rd    <= alu_rd;
            rsp_zflag <= alu_z;
            ptr       <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [NREQ-1:0][CNT_W-1:0] cnt_q;

    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)
                cnt_q[i] <= '0;
            else if (req_valid[i] && req_ready[i])
                cnt_q[i] <= sat_inc(cnt_q[i]);
        end
    end

    assign grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against a cycle-level reference model.
module tb_alu_arbiter;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NREQ-1:0]     req_valid, req_ready;
    logic [NREQ*32-1:0]  req_rs, req_rt;
    logic [NREQ*6-1:0]   req_funct;
    logic [NREQ*5-1:0]   req_shamt;
    logic                rsp_valid, rsp_ready, rsp_zflag;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_rd;
`ifdef ALU_ARB_STATS_EN
    logic [NREQ*16-1:0]  grant_cnt;
`endif

    int tests = 0;
    int fails = 0;

    bit          m_valid;
    int          m_id;
    logic [31:0] m_rd;
    bit          m_z;
    int          m_ptr;
    int          m_cnt [NREQ];

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_rt(req_rt), .req_funct(req_funct), .req_shamt(req_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_rd(rsp_rd), .rsp_zflag(rsp_zflag)
`ifdef ALU_ARB_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        case (f)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h00: return a << sh;
            6'h02: return a >> sh;
            6'h03: return 32'($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_grant();
        if (!rstn || (m_valid && !rsp_ready)) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready(input int g);
        logic [NREQ-1:0] e;
        e = '0;
        if (g >= 0) e[g] = 1'b1;
        return e;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_rd = 0; m_z = 0; m_ptr = 0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    task automatic model_clock(input int g);
        if (g >= 0) begin
            m_rd    = ref_alu(req_funct[6*g +: 6], req_rs[32*g +: 32], req_rt[32*g +: 32],
                              req_shamt[5*g +: 5]);
            m_z     = (m_rd == 0);
            m_valid = 1;
            m_id    = g;
            m_ptr   = (g + 1) % NREQ;
            if (m_cnt[g] < 65535) m_cnt[g]++;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic set_req(input int i, input bit v, input logic [5:0] f,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        req_valid[i]         = v;
        req_funct[6*i +: 6]  = f;
        req_rs[32*i +: 32]   = a;
        req_rt[32*i +: 32]   = b;
        req_shamt[5*i +: 5]  = sh;
    endtask

    // Assert reset, release between edges, return aligned at posedge+1.
    task automatic do_reset();
        rstn = 0; req_valid = '0; rsp_ready = 1;
        #12;
        rstn = 1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 0; rsp_ready = 1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 6'h20, 1, 2, 0);
        #12;
        tests++;
        if (req_ready !== '0) begin
            fails++; $display("FAIL reset_ready got=%b exp=0", req_ready);
        end
        tests++;
        if ({rsp_valid, rsp_id, rsp_rd, rsp_zflag} !== '0) begin
            fails++; $display("FAIL reset_rsp got v=%b id=%0d rd=%h z=%b exp all 0",
                              rsp_valid, rsp_id, rsp_rd, rsp_zflag);
        end
        req_valid = '0;
        do_reset();
    endtask

    task automatic test_contention();
        int g, first;
        first = m_ptr;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, 1, 6'h20, 32'(100*i + c), 32'(c), 0);
            rsp_ready = 1;
            #3;
            g = model_grant();
            tests++;
            if (req_ready !== exp_ready(g) || g != (first + c) % 2) begin
                fails++; $display("FAIL contention_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready(g));
            end
            @(posedge clk); model_clock(g); #1;
            tests++;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'((first + c) % 2) || rsp_rd !== m_rd) begin
                fails++; $display("FAIL contention_rsp c=%0d got id=%0d rd=%h exp id=%0d rd=%h",
                                  c, rsp_id, rsp_rd, (first + c) % 2, m_rd);
            end
        end
        req_valid = '0;
        @(posedge clk); model_clock(-1); #1;
    endtask

    task automatic test_single();
        int g;
        req_valid = '0;
        set_req(0, 1, 6'h20, 5, 7, 0);
        rsp_ready = 1;
        #3;
        g = model_grant();
        tests++;
        if (req_ready !== 2'b01) begin
            fails++; $display("FAIL single_ready got=%b exp=01", req_ready);
        end
        @(posedge clk); model_clock(g); #1;
        tests++;
        if (rsp_valid !== 1 || rsp_id !== 0 || rsp_rd !== 32'd12 || rsp_zflag !== 0) begin
            fails++; $display("FAIL single_rsp got v=%b id=%0d rd=%0d z=%b exp v=1 id=0 rd=12 z=0",
                              rsp_valid, rsp_id, rsp_rd, rsp_zflag);
        end
        req_valid = '0;
        @(posedge clk); model_clock(model_grant()); #1;
        tests++;
        if (rsp_valid !== 1'b0 || rsp_rd !== 32'd12) begin
            fails++; $display("FAIL drain got v=%b rd=%0d exp v=0 rd=12", rsp_valid, rsp_rd);
        end
    endtask

    task automatic test_backpressure();
        int g;
        logic [31:0] rd_s;
        logic [IDW-1:0] id_s;
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 6'h26, $urandom, $urandom, 0);
        rsp_ready = 1;
        #3;
        @(posedge clk); model_clock(model_grant()); #1;
        rd_s = rsp_rd; id_s = rsp_id;
        rsp_ready = 0;
        for (int c = 0; c < 3; c++) begin
            #3;
            g = model_grant();
            tests++;
            if (req_ready !== '0) begin
                fails++; $display("FAIL stall_ready c=%0d got=%b exp=0", c, req_ready);
            end
            @(posedge clk); model_clock(g); #1;
            tests++;
            if (rsp_valid !== 1'b1 || rsp_rd !== rd_s || rsp_id !== id_s || rsp_rd !== m_rd) begin
                fails++; $display("FAIL stall_hold c=%0d got v=%b id=%0d rd=%h exp v=1 id=%0d rd=%h",
                                  c, rsp_valid, rsp_id, rsp_rd, id_s, rd_s);
            end
        end
        rsp_ready = 1;
        #3;
        g = model_grant();
        tests++;
        if (req_ready === '0 || req_ready !== exp_ready(g)) begin
            fails++; $display("FAIL release_ready got=%b exp=%b", req_ready, exp_ready(g));
        end
        @(posedge clk); model_clock(g); #1;
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== IDW'(m_id) || rsp_rd !== m_rd) begin
            fails++; $display("FAIL release_rsp got id=%0d rd=%h exp id=%0d rd=%h", rsp_id, rsp_rd, m_id, m_rd);
        end
        req_valid = '0;
        @(posedge clk); model_clock(-1); #1;
    endtask

    task automatic test_ops();
        logic [5:0]  f  [3] = '{6'h03, 6'h22, 6'h3F};
        logic [31:0] a  [3] = '{32'h8000_0000, 32'd9, 32'h1234_5678};
        logic [31:0] b  [3] = '{32'h0000_0001, 32'd9, 32'h0000_0001};
        logic [31:0] er [3] = '{32'hF800_0000, 32'd0, 32'd0};
        bit          ez [3] = '{1'b0, 1'b1, 1'b1};
        int g;
        rsp_ready = 1;
        for (int t = 0; t < 3; t++) begin
            req_valid = '0;
            set_req(1, 1, f[t], a[t], b[t], 5'd4);
            #3;
            g = model_grant();
            @(posedge clk); model_clock(g); #1;
            tests++;
            if (rsp_valid !== 1 || rsp_id !== 1 || rsp_rd !== er[t] || rsp_zflag !== ez[t]) begin
                fails++; $display("FAIL ops t=%0d got v=%b id=%0d rd=%h z=%b exp v=1 id=1 rd=%h z=%b",
                                  t, rsp_valid, rsp_id, rsp_rd, rsp_zflag, er[t], ez[t]);
            end
        end
        req_valid = '0;
        @(posedge clk); model_clock(-1); #1;
    endtask

    task automatic test_random();
        logic [5:0] fl [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h3F};
        int g;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, ($urandom_range(0, 3) != 0), fl[$urandom_range(0, 9)],
                        ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, $urandom, 5'($urandom));
            rsp_ready = ($urandom_range(0, 9) < 7);
            #3;
            g = model_grant();
            tests++;
            if (req_ready !== exp_ready(g)) begin
                fails++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready(g));
            end
            @(posedge clk); model_clock(g); #1;
            tests++;
            if (rsp_valid !== m_valid || rsp_id !== IDW'(m_id) || rsp_rd !== m_rd || rsp_zflag !== m_z) begin
                fails++; $display("FAIL rand_rsp c=%0d got v=%b id=%0d rd=%h z=%b exp v=%b id=%0d rd=%h z=%b",
                                  c, rsp_valid, rsp_id, rsp_rd, rsp_zflag, m_valid, m_id, m_rd, m_z);
            end
        end
        req_valid = '0; rsp_ready = 1;
        @(posedge clk); model_clock(-1); #1;
    endtask

    task automatic test_async_reset();
        req_valid = '0;
        set_req(1, 1, 6'h20, 3, 4, 0);
        rsp_ready = 1;
        #3;
        @(posedge clk); model_clock(model_grant()); #1;
        rsp_ready = 0;
        #2;
        rstn = 0;
        #1;
        model_reset();
        tests++;
        if (rsp_valid !== 1'b0 || rsp_rd !== '0 || rsp_id !== '0 || req_ready !== '0) begin
            fails++; $display("FAIL async_reset got v=%b rd=%h id=%0d rdy=%b exp all 0",
                              rsp_valid, rsp_rd, rsp_id, req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0; rsp_ready = 1;
        #3 rstn = 1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); model_clock(model_grant()); #1;
            tests++;
            if (rsp_valid !== 1'b0) begin
                fails++; $display("FAIL stale_rsp c=%0d got v=%b exp v=0", c, rsp_valid);
            end
        end
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 6'h25, 1, 2, 0);
        #3;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++; $display("FAIL ptr_after_reset got=%b exp=01", req_ready);
        end
        @(posedge clk); model_clock(model_grant()); #1;
        req_valid = '0;
        @(posedge clk); model_clock(-1); #1;
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        tests++;
        if (grant_cnt !== '0) begin
            fails++; $display("FAIL stats_reset got=%h exp=0", grant_cnt);
        end
        req_valid = '0;
        set_req(0, 1, 6'h20, 1, 1, 0);
        rsp_ready = 1;
        for (int c = 0; c < 70000; c++) begin
            #3;
            @(posedge clk); model_clock(model_grant()); #1;
        end
        tests++;
        if (grant_cnt[15:0] !== 16'hFFFF || grant_cnt[31:16] !== 16'h0 ||
            grant_cnt[15:0] !== 16'(m_cnt[0])) begin
            fails++; $display("FAIL stats_sat got=%h exp=0000ffff", grant_cnt);
        end
        req_valid = '0;
    endtask
`endif

    initial begin
        rstn = 0;
        req_valid = '0; req_rs = '0; req_rt = '0; req_funct = '0; req_shamt = '0;
        rsp_ready = 1;
        model_reset();
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_ops();
        test_random();
        test_async_reset();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
